dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single
// line-wide data memory. One transaction is in flight at a time; the winner's
// command is latched on grant so the losing requester cannot disturb it.
// Optional feature: define DMEM_ARB_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles for mem_rdy (reported on err_0/err_1).
module dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_0,
  input  logic        we_0,
  input  logic [10:0] addr_0,
  input  logic [63:0] wdata_0,
  input  logic        re_1,
  input  logic        we_1,
  input  logic [10:0] addr_1,
  input  logic [63:0] wdata_1,
  output logic        grant_0,
  output logic        grant_1,
  output logic        done_0,
  output logic        done_1,
  output logic [63:0] rdata_0,
  output logic [63:0] rdata_1,
  output logic        err_0,
  output logic        err_1,
  output logic [10:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // A zero timeout would make the abort counter meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t r_state;
  logic   r_rr;     // requester preferred on contention (0 = CPU0)
  logic   r_owner;  // requester owning the in-flight transaction

  logic        w_req_0;
  logic        w_req_1;
  logic        w_pick_1;
  logic        w_win_we;
  logic [10:0] w_win_addr;
  logic [63:0] w_win_wdata;

  // Arbitration: a lone requester wins outright, contention goes to r_rr.
  // re+we together counts as a write, so only we decides the op.
  assign w_req_0     = re_0 | we_0;
  assign w_req_1     = re_1 | we_1;
  assign w_pick_1    = w_req_1 & (~w_req_0 | r_rr);
  assign w_win_we    = w_pick_1 ? we_1    : we_0;
  assign w_win_addr  = w_pick_1 ? addr_1  : addr_0;
  assign w_win_wdata = w_pick_1 ? wdata_1 : wdata_0;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;  // ACCESS cycles already spent without mem_rdy
`else
  assign err_0 = 1'b0;
  assign err_1 = 1'b0;
`endif

  // Arbiter FSM with all outputs registered in the same process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_owner   <= 1'b0;
      grant_0   <= 1'b0;
      grant_1   <= 1'b0;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      rdata_0   <= '0;
      rdata_1   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      err_0     <= 1'b0;
      err_1     <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins, so each
      // pulse lasts exactly one cycle without any extra clearing logic.
      done_0 <= 1'b0;
      done_1 <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      err_0  <= 1'b0;
      err_1  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req_0 || w_req_1) begin
            r_owner   <= w_pick_1;
            grant_0   <= ~w_pick_1;
            grant_1   <= w_pick_1;
            mem_addr  <= w_win_addr;
            mem_wdata <= w_win_wdata;
            mem_we    <= w_win_we;
            mem_re    <= ~w_win_we;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_rdy) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we) begin
              if (r_owner) rdata_1 <= mem_rdata;
              else         rdata_0 <= mem_rdata;
            end
            done_0  <= ~r_owner;
            done_1  <= r_owner;
            r_state <= S_DONE;
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            err_0   <= ~r_owner;
            err_1   <= r_owner;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          grant_0 <= 1'b0;
          grant_1 <= 1'b0;
          r_rr    <= ~r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter. Stimulus predicts the service order from
// the round-robin rule and pushes expected transactions; a monitor compares
// every d_mem command and every completion against the queue front.
module tb_dmem_arbiter;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re_0 = 0, we_0 = 0, re_1 = 0, we_1 = 0;
  logic [10:0] addr_0 = '0, addr_1 = '0;
  logic [63:0] wdata_0 = '0, wdata_1 = '0;
  logic        grant_0, grant_1, done_0, done_1, err_0, err_1;
  logic [63:0] rdata_0, rdata_1;
  logic [10:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_re, mem_we;
  logic [63:0] mem_rdata;
  logic        mem_rdy;

  dmem_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .re_0(re_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .re_1(re_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .err_0(err_0), .err_1(err_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cpu;
    bit          we;
    logic [10:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [63:0] ref_mem [2048];   // expected memory contents, in predicted order
  logic [63:0] dmem    [2048];   // memory seen by the DUT
  logic [63:0] exp_rdata [2];
  bit          rr_model;
  bit          mon_en = 0;
  int          rdy_dly = 1;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: got=%s", name, what);
  endtask

  // Expected service: writes update the reference memory, reads take its value.
  task automatic push_txn(input bit c, input bit we, input logic [10:0] a, input logic [63:0] d);
    txn_t t;
    t.cpu = c; t.we = we; t.addr = a; t.wdata = d; t.rdata = '0;
    if (we) ref_mem[a] = d;
    else    t.rdata = ref_mem[a];
    exp_q.push_back(t);
    rr_model = ~c;
  endtask

  // Memory responder: mem_rdy after rdy_dly strobe cycles; noise when idle.
  initial begin
    int cnt;
    cnt = 0;
    mem_rdy = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_rdy = 1'b0;
        cnt = 0;
      end else if (mem_re || mem_we) begin
        if (cnt == rdy_dly) begin
          mem_rdy = 1'b1;
          if (mem_we) dmem[mem_addr] = mem_wdata;
          else        mem_rdata = dmem[mem_addr];
          cnt = 0;
        end else begin
          mem_rdy = 1'b0;
          mem_rdata = {$urandom, $urandom};
          cnt++;
        end
      end else begin
        mem_rdy = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
        cnt = 0;
      end
    end
  end

  // Monitor: compares commands and completions against the scoreboard.
  initial begin
    bit   prev_fire;
    txn_t t;
    prev_fire = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_fire = 0;
        continue;
      end
      check("grant_overlap", grant_0 & grant_1, 0);
      check("strobe_overlap", mem_re & mem_we, 0);
      if (prev_fire) begin
        if (exp_q.size() == 0) fail_now("done_without_txn", "completion with empty queue");
        else begin
          t = exp_q.pop_front();
          if (!t.we) exp_rdata[t.cpu] = t.rdata;
          check("completion",
                {err_1, err_0, done_1, done_0, grant_1, grant_0, rdata_1, rdata_0},
                {2'b00, t.cpu ? 2'b10 : 2'b01, t.cpu ? 2'b10 : 2'b01, exp_rdata[1], exp_rdata[0]});
        end
      end else if ({err_1, err_0, done_1, done_0} != 4'b0) begin
        check("spurious_pulse", {err_1, err_0, done_1, done_0}, 0);
      end
      if (mem_re || mem_we) begin
        if (exp_q.size() == 0) fail_now("strobe_without_txn", "mem strobe with empty queue");
        else begin
          t = exp_q[0];
          check("mem_command",
                {grant_1, grant_0, mem_we, mem_re, mem_addr, t.we ? mem_wdata : 64'h0},
                {t.cpu ? 2'b10 : 2'b01, t.we, !t.we, t.addr, t.we ? t.wdata : 64'h0});
        end
      end
      prev_fire = (mem_re || mem_we) && mem_rdy;
    end
  end

  // One requester: raise the request, hold it until done/err, then drop it.
  task automatic cpu_req(input bit c, input bit re, input bit we, input logic [10:0] a,
                         input logic [63:0] d, output int lat, output bit got_err, output bit got_done);
    @(negedge clk);
    if (c) begin re_1 = re; we_1 = we; addr_1 = a; wdata_1 = d; end
    else   begin re_0 = re; we_0 = we; addr_0 = a; wdata_0 = d; end
    lat = 0; got_err = 0; got_done = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (c ? (done_1 || err_1) : (done_0 || err_0)) begin
        lat = i;
        got_err  = c ? err_1 : err_0;
        got_done = c ? done_1 : done_0;
        break;
      end
    end
    if (c) begin re_1 = 0; we_1 = 0; addr_1 = 11'($urandom); wdata_1 = {$urandom, $urandom}; end
    else   begin re_0 = 0; we_0 = 0; addr_0 = 11'($urandom); wdata_0 = {$urandom, $urandom}; end
    if (lat == 0) fail_now(c ? "cpu1_no_completion" : "cpu0_no_completion", "nothing within 200 cycles");
  endtask

  // Issue one or two simultaneous requests, predicting service order.
  task automatic run_pair(input bit r0, input bit r1,
                          input bit re0, input bit we0, input logic [10:0] a0, input logic [63:0] d0,
                          input bit re1, input bit we1, input logic [10:0] a1, input logic [63:0] d1,
                          input int dly);
    bit first;
    int lat0, lat1;
    bit e0, e1, dn0, dn1;
    lat0 = 0; lat1 = 0;
    rdy_dly = dly;
    first = (r0 && r1) ? rr_model : r1;
    if (first) push_txn(1, we1, a1, d1);
    else       push_txn(0, we0, a0, d0);
    if (r0 && r1) begin
      if (first) push_txn(0, we0, a0, d0);
      else       push_txn(1, we1, a1, d1);
    end
    fork
      begin if (r0) cpu_req(0, re0, we0, a0, d0, lat0, e0, dn0); end
      begin if (r1) cpu_req(1, re1, we1, a1, d1, lat1, e1, dn1); end
    join
    if (r0) check("latency_cpu0", lat0, (r1 && first) ? 5 + 2 * dly : 2 + dly);
    if (r1) check("latency_cpu1", lat1, (r0 && !first) ? 5 + 2 * dly : 2 + dly);
  endtask

  task automatic random_pair();
    bit r0, r1, re0, we0, re1, we1;
    int pat, op;
    logic [10:0] a0, a1;
    pat = $urandom_range(1, 3);
    r0 = pat[0]; r1 = pat[1];
    op = $urandom_range(0, 2); we0 = (op != 0); re0 = (op != 1);
    op = $urandom_range(0, 2); we1 = (op != 0); re1 = (op != 1);
    a0 = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
    a1 = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
    run_pair(r0, r1, re0, we0, a0, {$urandom, $urandom},
             re1, we1, a1, {$urandom, $urandom}, $urandom_range(1, 3));
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    rr_model = 0;
    mon_en = 1;
  endtask

  initial begin
    logic [63:0] v;
    bit          we_tab [2][2];
    logic [10:0] a_tab  [2][2];
    logic [63:0] d_tab  [2][2];
    int          idx [2];
    int          lat0, lat1, l;
    bit          e0, e1, dn0, dn1, e, dn, c;

    for (int i = 0; i < 2048; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
      dmem[i] = v;
    end
    v = 64'h0123456789ABCDEF;
    ref_mem[11'h012] = v;
    dmem[11'h012] = v;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ctrl", {grant_0, grant_1, done_0, done_1, err_0, err_1, mem_re, mem_we,
                         mem_addr, mem_wdata}, 0);
    check("reset_rdata", {rdata_0, rdata_1}, 0);
    rst = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rr_model = 0;
    mon_en = 1;

    // CPU0 read of 0x012, ready on the second strobe cycle: done at cycle 3.
    run_pair(1, 0, 1, 0, 11'h012, '0, 0, 0, '0, '0, 1);
    check("read_0x012_rdata0", rdata_0, 64'h0123456789ABCDEF);
    check("read_0x012_rdata1", rdata_1, 64'h0);

    // Simultaneous writes after reset: CPU0 first, CPU1 second.
    do_reset();
    run_pair(1, 1, 0, 1, 11'h0A5, 64'hAAAA_5555_0000_FFFF, 0, 1, 11'h0A6, 64'h1234_5678_9ABC_DEF0, 2);

    // CPU1 with re and we together behaves as a write to 0x7FF.
    run_pair(0, 1, 0, 0, '0, '0, 1, 1, 11'h7FF, 64'hFEED_FACE_CAFE_BEEF, 1);

    // Continuous contention for four transactions, ready after one cycle.
    do_reset();
    we_tab = '{'{1'b1, 1'b0}, '{1'b0, 1'b1}};
    a_tab  = '{'{11'h100, 11'h100}, '{11'h200, 11'h201}};
    d_tab  = '{'{64'h1111_2222_3333_4444, 64'h0}, '{64'h0, 64'h5555_6666_7777_8888}};
    idx[0] = 0; idx[1] = 0;
    rdy_dly = 1;
    for (int k = 0; k < 4; k++) begin
      c = rr_model;
      push_txn(c, we_tab[c][idx[c]], a_tab[c][idx[c]], d_tab[c][idx[c]]);
      idx[c]++;
    end
    fork
      begin
        for (int j = 0; j < 2; j++) cpu_req(0, !we_tab[0][j], we_tab[0][j], a_tab[0][j], d_tab[0][j], l, e, dn);
      end
      begin
        for (int j = 0; j < 2; j++) cpu_req(1, !we_tab[1][j], we_tab[1][j], a_tab[1][j], d_tab[1][j], lat1, e1, dn1);
      end
    join

    // Randomized traffic.
    for (int n = 0; n < 40; n++) random_pair();

    // Reset pulsed in the middle of an access.
    mon_en = 0;
    rdy_dly = 1000;
    @(negedge clk);
    we_0 = 1; re_0 = 0; addr_0 = 11'h155; wdata_0 = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    check("abort_pre_rst", {grant_0, mem_we, mem_addr}, {1'b1, 1'b1, 11'h155});
    #2 rst = 1;
    #1 check("abort_immediate", {grant_0, grant_1, mem_we, mem_re, mem_addr, mem_wdata, done_0, err_0}, 0);
    we_0 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {done_0, done_1, err_0, err_1, grant_0, grant_1}, 0);
    end
    exp_q.delete();
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rr_model = 0;
    mon_en = 1;
    run_pair(1, 1, 1, 0, 11'h003, '0, 0, 1, 11'h004, 64'h0BAD_F00D_0BAD_F00D, 2);
    for (int n = 0; n < 10; n++) random_pair();

`ifdef DMEM_ARB_TIMEOUT_EN
    // Memory never answers CPU0: err_0 after the timeout, then CPU1 is served.
    do_reset();
    mon_en = 0;
    rdy_dly = 1000;
    fork
      begin
        cpu_req(0, 0, 1, 11'h020, 64'hDEAD_DEAD_DEAD_DEAD, lat0, e0, dn0);
        rdy_dly = 1;
      end
      cpu_req(1, 1, 0, 11'h030, '0, lat1, e1, dn1);
    join
    check("timeout_cpu0", {lat0[7:0], e0, dn0}, {8'(TB_TIMEOUT + 1), 1'b1, 1'b0});
    check("timeout_then_cpu1", {lat1[7:0], e1, dn1}, {8'(TB_TIMEOUT + 5), 1'b0, 1'b1});
    check("timeout_rdata", {rdata_0, rdata_1}, {64'h0, ref_mem[11'h030]});
    check("timeout_no_write", dmem[11'h020], ref_mem[11'h020]);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
